// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the MEM/WB stage: default entry layout and
//               buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DATA_W = 64;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              memtoreg;
        logic              regwrite;
    } mem_wb_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Generic-width 2-entry valid/ready buffer with synchronous
//               flush; optional skid entry gives a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int WIDTH   = 8,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import pipe_pkg::*;

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;

    // With the skid entry, in_ready depends only on the state flop.
    generate
        if (SKID_EN != 0) begin : g_reg_ready
            assign w_in_ready = (r_state != SKID);
        end else begin : g_comb_ready
            assign w_in_ready = (r_state == EMPTY) | out_ready;
        end
    endgenerate

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;
    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = (r_state != EMPTY) & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_load_main = 1'b1;
                end
            end
            FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = SKID;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (w_out_xfer) begin
                    w_state_nxt      = FULL;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush wins over any same-cycle capture.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_main <= '0;
                r_skid <= '0;
            end else begin
                if (w_load_main) begin
                    r_main <= in_data;
                end else if (w_main_from_skid) begin
                    r_main <= r_skid;
                end
                if (w_load_skid) begin
                    r_skid <= in_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline stage: handshake buffer plus write-enable
//               gating and writeback data selection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
    parameter int DATA_W       = 64,
    parameter int RD_W         = 5,
    parameter int SKID_EN      = 1,
    parameter int ZERO_RD_KILL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] result,
    input  logic [RD_W-1:0]   rd,
    input  logic              memtoreg,
    input  logic              regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic [DATA_W-1:0] out_wb_data
);
    import pipe_pkg::*;

    localparam int c_ENTRY_W = 2 * DATA_W + RD_W + 2;

    // Same layout as mem_wb_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              memtoreg;
        logic              regwrite;
    } entry_t;

    entry_t                 w_in_entry;
    entry_t                 w_main;
    logic [c_ENTRY_W-1:0]   w_main_bits;
    logic                   w_out_valid;
    logic                   w_rd_kill;

    assign w_in_entry = {read_data, result, rd, memtoreg, regwrite};

    skid_buffer #(
        .WIDTH   (c_ENTRY_W),
        .SKID_EN (SKID_EN)
    ) u_skid_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_main_bits)
    );

    assign w_main = w_main_bits;

    // x0 is hardwired, so a write to it must never reach the register file.
    assign w_rd_kill = (ZERO_RD_KILL != 0) && (w_main.rd == '0);

    assign out_valid     = w_out_valid;
    assign out_read_data = w_main.read_data;
    assign out_result    = w_main.result;
    assign out_rd        = w_main.rd;
    assign out_memtoreg  = w_main.memtoreg;
    assign out_regwrite  = w_main.regwrite & w_out_valid & ~w_rd_kill;
    assign out_wb_data   = w_main.memtoreg ? w_main.read_data : w_main.result;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Directed and scoreboarded bench for mem_wb_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] read_data = '0;
    logic [63:0] result = '0;
    logic [4:0]  rd = '0;
    logic        memtoreg = 1'b0;
    logic        regwrite = 1'b0;

    logic        in_ready, out_valid, out_memtoreg, out_regwrite;
    logic [63:0] out_read_data, out_result, out_wb_data;
    logic [4:0]  out_rd;

    logic        nk_in_ready, nk_out_valid, nk_out_memtoreg, nk_out_regwrite;
    logic [63:0] nk_out_read_data, nk_out_result, nk_out_wb_data;
    logic [4:0]  nk_out_rd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_pipe dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .read_data(read_data), .result(result), .rd(rd), .memtoreg(memtoreg), .regwrite(regwrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_read_data(out_read_data),
        .out_result(out_result), .out_rd(out_rd), .out_memtoreg(out_memtoreg),
        .out_regwrite(out_regwrite), .out_wb_data(out_wb_data)
    );

    mem_wb_pipe #(.ZERO_RD_KILL(0)) dut_nk (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nk_in_ready),
        .read_data(read_data), .result(result), .rd(rd), .memtoreg(memtoreg), .regwrite(regwrite),
        .out_valid(nk_out_valid), .out_ready(out_ready), .out_read_data(nk_out_read_data),
        .out_result(nk_out_result), .out_rd(nk_out_rd), .out_memtoreg(nk_out_memtoreg),
        .out_regwrite(nk_out_regwrite), .out_wb_data(nk_out_wb_data)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] rdat, input logic [63:0] res,
                         input logic [4:0] r, input logic m2r, input logic rw);
        in_valid  = v;
        read_data = rdat;
        result    = res;
        rd        = r;
        memtoreg  = m2r;
        regwrite  = rw;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_regwrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %0b want 0", out_regwrite); end
        n_vec++; if (out_wb_data !== 64'h0) begin n_err++; $display("FAIL reset_wb_data: got %0h want 0", out_wb_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_alu_path;
        out_ready = 1'b1;
        drive(1'b1, 64'h5555, 64'h1234, 5'd5, 1'b0, 1'b1);
        cyc();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_wb_data !== 64'h1234) begin n_err++; $display("FAIL alu_wb_data: got %0h want 1234", out_wb_data); end
        n_vec++; if (out_regwrite !== 1'b1) begin n_err++; $display("FAIL alu_regwrite: got %0b want 1", out_regwrite); end
        n_vec++; if (out_rd !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", out_rd); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL alu_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_load_path;
        out_ready = 1'b1;
        drive(1'b1, 64'hDEAD_BEEF, 64'h10, 5'd7, 1'b1, 1'b1);
        cyc();
        n_vec++; if (out_wb_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL load_wb_data: got %0h want deadbeef", out_wb_data); end
        n_vec++; if (out_result !== 64'h10) begin n_err++; $display("FAIL load_result: got %0h want 10", out_result); end
        n_vec++; if (out_memtoreg !== 1'b1) begin n_err++; $display("FAIL load_memtoreg: got %0b want 1", out_memtoreg); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 64'hA, 5'd1, 1'b0, 1'b1);
        cyc();
        n_vec++; if (out_rd !== 5'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_a_held: got rd %0d valid %0b want rd 1 valid 1", out_rd, out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_full_ready: got %0b want 1", in_ready); end
        drive(1'b1, 64'h0, 64'hB, 5'd2, 1'b0, 1'b1);
        cyc();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_skid_ready: got %0b want 0", in_ready); end
        drive(1'b1, 64'h0, 64'hC, 5'd3, 1'b0, 1'b1);
        cyc();
        n_vec++; if (out_rd !== 5'd1 || out_wb_data !== 64'hA) begin n_err++; $display("FAIL bp_a_stable: got rd %0d data %0h want rd 1 data a", out_rd, out_wb_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_c_blocked: got %0b want 0", in_ready); end
        out_ready = 1'b1;
        cyc();
        n_vec++; if (out_rd !== 5'd2 || out_wb_data !== 64'hB) begin n_err++; $display("FAIL bp_b_next: got rd %0d data %0h want rd 2 data b", out_rd, out_wb_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
        cyc();
        n_vec++; if (out_rd !== 5'd3 || out_wb_data !== 64'hC) begin n_err++; $display("FAIL bp_c_next: got rd %0d data %0h want rd 3 data c", out_rd, out_wb_data); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 64'hD, 5'd9, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 64'h0, 64'hE, 5'd10, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 64'h0, 64'hF, 5'd11, 1'b0, 1'b1);
        flush = 1'b1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_skid_ready: got %0b want 0", in_ready); end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_regwrite !== 1'b0) begin n_err++; $display("FAIL flush_regwrite: got %0b want 0", out_regwrite); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost: got %0b want 0", out_valid); end
        end
        // Flush while FULL with an input the stage is ready for: input dropped.
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 64'h12, 5'd12, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 64'h0, 64'h13, 5'd13, 1'b0, 1'b1);
        flush = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready: got %0b want 1", in_ready); end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_drop: got %0b want 0", out_valid); end
        cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_ghost: got %0b want 0", out_valid); end
    endtask

    task automatic test_zero_rd;
        out_ready = 1'b1;
        drive(1'b1, 64'h0, 64'h77, 5'd0, 1'b0, 1'b1);
        cyc();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zrd_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_regwrite !== 1'b0) begin n_err++; $display("FAIL zrd_kill: got %0b want 0", out_regwrite); end
        n_vec++; if (nk_out_regwrite !== 1'b1) begin n_err++; $display("FAIL zrd_nokill: got %0b want 1", nk_out_regwrite); end
        n_vec++; if (out_wb_data !== 64'h77) begin n_err++; $display("FAIL zrd_wb_data: got %0h want 77", out_wb_data); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 64'h44, 5'd4, 1'b0, 1'b1);
        cyc();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %0b want 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_regwrite !== 1'b0) begin n_err++; $display("FAIL areset_regwrite: got %0b want 0", out_regwrite); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random;
        mem_wb_t     q[$];
        mem_wb_t     e;
        logic        exp_ready, exp_valid, in_x, out_x;
        logic [63:0] exp_wb;
        for (int i = 0; i < 104; i++) begin
            exp_ready = (q.size() < 2);
            exp_valid = (q.size() > 0);
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_in_ready cyc %0d: got %0b want %0b", i, in_ready, exp_ready); end
            n_vec++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_out_valid cyc %0d: got %0b want %0b", i, out_valid, exp_valid); end
            if (exp_valid) begin
                exp_wb = q[0].memtoreg ? q[0].read_data : q[0].result;
                n_vec++; if (out_rd !== q[0].rd || out_wb_data !== exp_wb) begin n_err++; $display("FAIL rnd_data cyc %0d: got rd %0d data %0h want rd %0d data %0h", i, out_rd, out_wb_data, q[0].rd, exp_wb); end
                n_vec++; if (out_regwrite !== (q[0].regwrite && q[0].rd != 5'd0)) begin n_err++; $display("FAIL rnd_regwrite cyc %0d: got %0b want %0b", i, out_regwrite, q[0].regwrite && q[0].rd != 5'd0); end
            end
            if (i < 100) begin
                drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 9) == 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                flush     = 1'b0;
            end
            in_x  = in_valid && exp_ready;
            out_x = exp_valid && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) begin
                    e.read_data = read_data;
                    e.result    = result;
                    e.rd        = rd;
                    e.memtoreg  = memtoreg;
                    e.regwrite  = regwrite;
                    q.push_back(e);
                end
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_load_path();
        test_backpressure();
        test_flush();
        test_zero_rd();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake.
- Optional 2-entry skid buffer, so in_ready is driven from a flop.
- Synchronous flush; bubbles are marked invalid and have their write enables suppressed.
- Sits between the data-memory stage and register-file writeback. Also supplies the selected writeback value (load data or ALU result) so WB logic is not duplicated elsewhere.

Parameters:
- DATA_W, 64, width of read_data, result and wb_data
- RD_W, 5, destination register index width
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- ZERO_RD_KILL, 1, 1 = force out_regwrite low when out_rd == 0 (x0 hardwired)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream (EX/MEM) entry valid
- in_ready  out  1  stage can accept an entry this cycle
- read_data  in  DATA_W  data-memory load value
- result  in  DATA_W  ALU result
- rd  in  RD_W  destination register
- memtoreg  in  1  1 = write back read_data, 0 = write back result
- regwrite  in  1  register-file write enable
- out_valid  out  1  held entry valid
- out_ready  in  1  writeback consumes entry (tie 1 if never stalls)
- out_read_data  out  DATA_W  held read_data
- out_result  out  DATA_W  held result
- out_rd  out  RD_W  held rd
- out_memtoreg  out  1  held memtoreg
- out_regwrite  out  1  gated write enable
- out_wb_data  out  DATA_W  out_memtoreg ? out_read_data : out_result (combinational from main entry)

Behaviour:
- Reset (async assert; deassert is synchronous to clk):
  - all stored fields = 0, both entries invalid
  - out_valid = 0, out_regwrite = 0, out_wb_data = 0
  - in_ready = 1 in the first cycle after deassertion
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. Both are sampled on the rising edge.
- Latency: 1 cycle from accepted input to out_valid. Throughput 1 entry/cycle while out_ready stays high.
- State machine (SKID_EN=1), entries main and skid:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> FULL (main <= inputs).
  - FULL: out_valid=1, in_ready=1.
    - input & output transfer -> FULL, main <= inputs
    - input only -> SKID, skid <= inputs
    - output only -> EMPTY
    - neither -> hold
  - SKID: out_valid=1, in_ready=0 (registered). Output transfer -> FULL, main <= skid; otherwise hold.
- SKID_EN=0: single entry; in_ready = ~out_valid | out_ready (combinational); states EMPTY/FULL only.
- Field loads: all fields of an entry load together. Fields in invalid entries are don't-care except memtoreg and regwrite, which are cleared on flush and reset.
- out_regwrite = main.regwrite & out_valid & ~(ZERO_RD_KILL & (out_rd == 0)).
- Flush:
  - next state EMPTY; both entries invalid; stored regwrite cleared
  - flush overrides a same-cycle input transfer: input dropped, in_ready still reported as in SKID-less terms for that cycle, entry not captured
  - a same-cycle output transfer of the old main entry is still counted downstream, since out_valid was high that cycle
- Reset mid-operation (any state) -> EMPTY immediately, without waiting for a clock edge.
- Data outputs are stable while out_valid=1 and out_ready=0. Verification checks this.
- No combinational path in_valid -> out_valid. With SKID_EN=1 there is no combinational path out_ready -> in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - struct mem_wb_t {read_data, result, rd, memtoreg, regwrite}, parametrised via DATA_W/RD_W localparams
  - state enum {EMPTY, FULL, SKID}
- One natural sub-module: skid_buffer, a generic payload-width, 2-entry valid/ready buffer holding the packed mem_wb_t.
- mem_wb_pipe adds flush, regwrite gating and the wb_data mux around skid_buffer.

Test Plan:
- Reset, then in_valid=1, result=0x1234, rd=5, regwrite=1, memtoreg=0, out_ready=1 -> next cycle out_valid=1, out_wb_data=0x1234, out_regwrite=1.
- Load path: read_data=0xDEAD_BEEF, result=0x10, memtoreg=1 -> out_wb_data=0xDEAD_BEEF.
- Backpressure: out_ready=0, 3 back-to-back inputs A,B,C -> A held on outputs, B in skid, in_ready=0, C not accepted. out_ready=1 -> A then B emitted in order; C is accepted only after in_ready returns to 1.
- Flush in SKID state with in_valid=1 -> next cycle out_valid=0, out_regwrite=0, in_ready=1, and the flushed-cycle input never appears at the outputs.
- rd=0, regwrite=1, ZERO_RD_KILL=1 -> out_valid=1, out_regwrite=0. Repeat with ZERO_RD_KILL=0 -> out_regwrite=1.
- Assert reset asynchronously mid-cycle while in FULL -> out_valid falls without a clock edge. After deassertion, run 100 random in_valid/out_ready/flush cycles against a scoreboard: no loss, no duplication, order preserved.
